// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, NOP encoding, fetch entry payload.
package cpu_pkg;

   localparam int unsigned XLEN = 32;

   // addi x0, x0, 0
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   // One fetched instruction together with the address it came from
   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] instr;
   } instr_entry_t;

   // Sequential next PC, wrapping at 2^XLEN
   function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
      return pc + XLEN'(4);
   endfunction

   // Force an address onto a word boundary
   function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
      return addr & ~XLEN'(3);
   endfunction

endpackage

// File: rtl/instr_prefetch_unit_fifo.sv
// prefetch_fifo: synchronous FIFO of fetched {pc, instr} entries.
// Flush has priority over push and pop; pop on empty and push on full are ignored.
module prefetch_fifo
   import cpu_pkg::*;
#(
   parameter int unsigned DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   push,
   input  instr_entry_t           push_data,
   input  logic                   pop,
   input  logic                   flush,
   output instr_entry_t           head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

   instr_entry_t  mem [DEPTH];
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   // Qualify requests against occupancy
   always_comb begin
      empty   = (count == '0);
      full    = (count == FULL_COUNT);
      do_pop  = pop & ~empty;
      do_push = push & (~full | do_pop);
      head    = mem[rd_ptr];
   end

   // Pointer and occupancy tracking
   always_ff @(posedge clk) begin
      if (!rst) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
   end

   // Entry storage; contents are don't-care until written
   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/instr_prefetch_unit.sv
// instr_prefetch_unit: handshaked instruction prefetcher for the fetch stage.
// Optional feature macro: PREFETCH_BYPASS_EN (response forwarded straight to
// the outputs when nothing is buffered, saving a cycle of fetch latency).
module instr_prefetch_unit
   import cpu_pkg::*;
#(
   parameter int unsigned     FIFO_DEPTH = 4,
   parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000
) (
   input  logic            clk,
   input  logic            rst,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_rsp_valid,
   input  logic [XLEN-1:0] imem_rsp_data,
   input  logic            StallF,
   input  logic            PCSrcE,
   input  logic [XLEN-1:0] PCTargetE,
   output logic [XLEN-1:0] InstrF,
   output logic [XLEN-1:0] PCF,
   output logic [XLEN-1:0] PCPlus4F,
   output logic            InstrValidF
);

   localparam int unsigned    CNT_W   = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CNT_W:0] CREDITS = (CNT_W+1)'(FIFO_DEPTH);

   logic [XLEN-1:0]  fetch_pc;
   logic [XLEN-1:0]  expected_pc;
   logic [CNT_W-1:0] out_cnt;
   logic [CNT_W-1:0] drop_cnt;
   logic [CNT_W-1:0] fifo_count;
   logic [CNT_W:0]   in_use;
   logic             run;

   instr_entry_t     head;
   instr_entry_t     push_entry;
   logic             fifo_full;
   logic             fifo_empty;
   logic             push;
   logic             take;
   logic             accept;
   logic             rsp_keep;
   logic             bypass;

   // Request side: issue while buffered + live in-flight slots leave room
   always_comb begin
      in_use         = (CNT_W+1)'(fifo_count) + (CNT_W+1)'(out_cnt) - (CNT_W+1)'(drop_cnt);
      imem_req_valid = run & (in_use < CREDITS);
      imem_req_addr  = fetch_pc;
      accept         = imem_req_valid & imem_req_ready;
   end

   // Same-cycle forwarding of a response into an empty buffer
   always_comb begin
`ifdef PREFETCH_BYPASS_EN
      bypass = fifo_empty & imem_rsp_valid & (drop_cnt == '0);
`else
      bypass = 1'b0;
`endif
   end

   // Fetch/decode boundary: head entry, forwarded response, or bubble
   always_comb begin
      InstrValidF = 1'b0;
      InstrF      = NOP_INSTR;
      PCF         = expected_pc;
      if (!fifo_empty) begin
         InstrValidF = 1'b1;
         InstrF      = head.instr;
         PCF         = head.pc;
      end else if (bypass) begin
         InstrValidF = 1'b1;
         InstrF      = imem_rsp_data;
      end
      PCPlus4F = next_pc(PCF);
   end

   // Consume and capture decisions
   always_comb begin
      take             = InstrValidF & ~StallF;
      rsp_keep         = imem_rsp_valid & ~PCSrcE & (drop_cnt == '0);
      push             = rsp_keep & ~fifo_full & ~(bypass & take);
      push_entry.pc    = expected_pc;
      push_entry.instr = imem_rsp_data;
   end

   prefetch_fifo #(
      .DEPTH     (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (take),
      .flush     (PCSrcE),
      .head      (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Fetch address, response bookkeeping and redirect recovery
   always_ff @(posedge clk) begin
      if (!rst) begin
         run         <= 1'b0;
         fetch_pc    <= RESET_PC;
         expected_pc <= RESET_PC;
         out_cnt     <= '0;
         drop_cnt    <= '0;
      end else begin
         run     <= 1'b1;
         out_cnt <= out_cnt + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
         if (PCSrcE) begin
            // Everything still in flight, including this cycle's response, is wrong-path
            fetch_pc    <= align_word(PCTargetE);
            expected_pc <= align_word(PCTargetE);
            drop_cnt    <= out_cnt + CNT_W'(accept) - CNT_W'(imem_rsp_valid);
         end else begin
            if (accept) fetch_pc <= next_pc(fetch_pc);
            if (imem_rsp_valid) begin
               if (drop_cnt != '0) drop_cnt    <= drop_cnt - CNT_W'(1);
               else                expected_pc <= next_pc(expected_pc);
            end
         end
      end
   end

endmodule

// File: tb/tb_instr_prefetch_unit.sv
// Scoreboard bench for instr_prefetch_unit: in-order memory model returning
// the request address as data, expected PC stream queued by the stimulus.
module tb_instr_prefetch_unit;

   localparam int unsigned FIFO_DEPTH = 4;
   localparam logic [31:0] RESET_PC   = 32'h0000_0000;
   localparam logic [31:0] NOP        = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data  = 32'h0;
   logic        StallF = 1'b0;
   logic        PCSrcE = 1'b0;
   logic [31:0] PCTargetE = 32'h0;
   logic [31:0] InstrF;
   logic [31:0] PCF;
   logic [31:0] PCPlus4F;
   logic        InstrValidF;

   int checks = 0;
   int errors = 0;
   int n_deliv = 0;

   logic [31:0] exp_q [$];
   logic [31:0] exp_tail = 32'h0;
   logic [31:0] mon_e;

   typedef struct {
      logic [31:0] addr;
      int          due;
   } mreq_t;
   mreq_t mq [$];
   mreq_t mr;
   int    cyc = 0;
   int    dmin = 1;
   int    dmax = 1;
   bit    ready_rand = 1'b0;

   instr_prefetch_unit #(
      .FIFO_DEPTH     (FIFO_DEPTH),
      .RESET_PC       (RESET_PC)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .StallF         (StallF),
      .PCSrcE         (PCSrcE),
      .PCTargetE      (PCTargetE),
      .InstrF         (InstrF),
      .PCF            (PCF),
      .PCPlus4F       (PCPlus4F),
      .InstrValidF    (InstrValidF)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic check1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b", name, act, exp);
      end
   endtask

   task automatic top_up();
      while (exp_q.size() < 32) begin
         exp_q.push_back(exp_tail);
         exp_tail = exp_tail + 32'd4;
      end
   endtask

   task automatic restart_expect(input logic [31:0] base);
      exp_q.delete();
      exp_tail = base & ~32'h3;
      top_up();
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      top_up();
   endtask

   // In-order memory: accepted request answered after dmin..dmax cycles
   always @(posedge clk) begin
      if (!rst) begin
         mq.delete();
      end else begin
         if (imem_rsp_valid) mr = mq.pop_front();
         if (imem_req_valid && imem_req_ready) begin
            mr.addr = imem_req_addr;
            mr.due  = cyc + int'($urandom_range(dmin, dmax));
            mq.push_back(mr);
         end
      end
      cyc++;
      #2;
      imem_req_ready = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      if (rst && mq.size() > 0 && mq[0].due <= cyc) begin
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mq[0].addr;
      end else begin
         imem_rsp_valid = 1'b0;
         imem_rsp_data  = 32'hDEAD_BEEF;
      end
   end

   // Monitor: every taken instruction must be the next expected one
   always @(negedge clk) begin
      if (rst && InstrValidF && !StallF && !PCSrcE) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_delivery actual_pc=%h expected=none", PCF);
         end else begin
            mon_e = exp_q.pop_front();
            check("deliver_pc", PCF, mon_e);
            check("deliver_instr", InstrF, mon_e);
            check("deliver_pcplus4", PCPlus4F, mon_e + 32'd4);
            n_deliv++;
         end
      end
   end

   task automatic do_reset();
      rst    = 1'b0;
      PCSrcE = 1'b0;
      step();
      step();
      check1("rst_req_valid", imem_req_valid, 1'b0);
      check("rst_req_addr", imem_req_addr, RESET_PC);
      check1("rst_instr_valid", InstrValidF, 1'b0);
      check("rst_instr", InstrF, NOP);
      check("rst_pcf", PCF, RESET_PC);
      check("rst_pcplus4", PCPlus4F, RESET_PC + 32'd4);
      restart_expect(RESET_PC);
      rst = 1'b1;
   endtask

   initial begin
      int          base;
      int          acc;
      bit          prev_redir;
      logic [31:0] last_tgt;

      // Back-to-back streaming from reset, k = 1
      StallF = 1'b0;
      dmin = 1; dmax = 1;
      do_reset();
      check1("release_cycle_no_req", imem_req_valid, 1'b0);
      step();
      check1("first_req_valid", imem_req_valid, 1'b1);
      check("first_req_addr", imem_req_addr, 32'h0);
      check1("first_not_valid_c1", InstrValidF, 1'b0);
      step();
      check1("first_not_valid_c2", InstrValidF, 1'b0);
      step();
      check1("first_valid_c3", InstrValidF, 1'b1);
      check("first_pcf_c3", PCF, 32'h0);
      for (int i = 0; i < 8; i++) begin
         step();
         check1("b2b_valid", InstrValidF, 1'b1);
      end

      // Stalled consumer exhausts credit, then drains in order
      StallF = 1'b1;
      do_reset();
      acc = 0;
      for (int i = 1; i <= 10; i++) begin
         step();
         if (imem_req_valid && imem_req_ready) acc++;
         if (i >= 3) begin
            check1("stall_head_valid", InstrValidF, 1'b1);
            check("stall_head_pc", PCF, 32'h0);
         end
      end
      check("stall_accepts", 32'(acc), 32'd4);
      check1("stall_req_dropped", imem_req_valid, 1'b0);
      base = n_deliv;
      StallF = 1'b0;
      repeat (12) step();
      check1("stall_drained", (n_deliv - base) >= 8, 1'b1);

      // Redirect with two responses outstanding (k = 3)
      dmin = 3; dmax = 3;
      do_reset();
      step();
      step();
      step();
      PCSrcE = 1'b1;
      PCTargetE = 32'h0000_0100;
      restart_expect(32'h0000_0100);
      step();
      check1("redir_invalid", InstrValidF, 1'b0);
      check1("redir_req_valid", imem_req_valid, 1'b1);
      check("redir_req_addr", imem_req_addr, 32'h0000_0100);
      check("redir_pcf", PCF, 32'h0000_0100);
      PCSrcE = 1'b0;
      base = n_deliv;
      repeat (12) step();
      check1("redir_delivers", n_deliv > base, 1'b1);

      // Unaligned target is forced onto a word boundary
      PCSrcE = 1'b1;
      PCTargetE = 32'h0000_0103;
      restart_expect(32'h0000_0100);
      step();
      check1("unal_invalid", InstrValidF, 1'b0);
      check("unal_req_addr", imem_req_addr, 32'h0000_0100);
      PCSrcE = 1'b0;
      repeat (12) step();

      // Redirect coinciding with a response and a take; target near 2^32 wrap
      dmin = 1; dmax = 1;
      repeat (16) step();
      PCSrcE = 1'b1;
      PCTargetE = 32'hFFFF_FFFA;
      restart_expect(32'hFFFF_FFF8);
      check1("coin_take_pending", InstrValidF, 1'b1);
      #2;
      check1("coin_rsp_pending", imem_rsp_valid, 1'b1);
      step();
      check1("coin_invalid", InstrValidF, 1'b0);
      check1("coin_req_valid", imem_req_valid, 1'b1);
      check("coin_req_addr", imem_req_addr, 32'hFFFF_FFF8);
      check("coin_pcf", PCF, 32'hFFFF_FFF8);
      check("coin_pcplus4", PCPlus4F, 32'hFFFF_FFFC);
      PCSrcE = 1'b0;
      base = n_deliv;
      repeat (12) step();
      check1("wrap_delivers", (n_deliv - base) >= 4, 1'b1);

      // Random ready, latency, stalls and redirects
      ready_rand = 1'b1;
      dmin = 1; dmax = 3;
      base = n_deliv;
      prev_redir = 1'b0;
      last_tgt = 32'h0;
      for (int i = 0; i < 1000; i++) begin
         step();
         if (prev_redir) begin
            check1("rnd_redir_invalid", InstrValidF, 1'b0);
            check1("rnd_redir_req_valid", imem_req_valid, 1'b1);
            check("rnd_redir_addr", imem_req_addr, last_tgt & ~32'h3);
         end
         StallF = ($urandom_range(0, 3) == 0);
         if ($urandom_range(0, 24) == 0) begin
            if ($urandom_range(0, 3) == 0) PCTargetE = 32'hFFFF_FFF0 | $urandom_range(0, 15);
            else                           PCTargetE = $urandom() & 32'h0000_0FFF;
            last_tgt   = PCTargetE;
            PCSrcE     = 1'b1;
            prev_redir = 1'b1;
            restart_expect(PCTargetE);
         end else begin
            PCSrcE     = 1'b0;
            prev_redir = 1'b0;
         end
      end
      PCSrcE = 1'b0;
      StallF = 1'b0;
      ready_rand = 1'b0;
      repeat (20) step();
      check1("rnd_delivers", (n_deliv - base) > 100, 1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
